vga_frame_ctrl: RTL and testbench
=================================

# vga_frame_ctrl

Frame-synchronous register controller that sits between the Avalon slave port and the VGA pixel generator. Software writes colour and position into a shadow bank; the block commits the bank to the active registers only at the start of vertical blanking, so no frame shows a half-updated sprite. It also counts frames, raises a per-commit interrupt pulse and exposes status for polling.

## Interface
- Parameters:
  - HTOTAL, 1600: clk cycles per line.
  - VACTIVE, 480: visible lines.
  - VTOTAL, 525: lines per frame.
- Ports:
  - clk  in  1  50 MHz system clock.
  - reset  in  1  synchronous, active-high reset. The whole block is in the single clk domain.
  - chipselect  in  1  Avalon select.
  - write  in  1  Avalon write strobe.
  - read  in  1  Avalon read strobe.
  - address  in  4  register index.
  - writedata  in  8  write data.
  - readdata  out  8  registered read data.
  - hcount  in  11  from vga_counters, 0..HTOTAL-1.
  - vcount  in  10  from vga_counters, 0..VTOTAL-1.
  - r, g, b  out  8 each  active colour to the pixel generator.
  - pos_x, pos_y  out  8 each  active sprite position.
  - frame_count  out  8  frames since reset, wraps.
  - irq  out  1  one-cycle pulse per commit.

## Operation
- Register map, writes when chipselect && write:
  - 0 r, 1 g, 2 b, 3 pos_x, 4 pos_y go to the shadow bank.
  - 5 CTRL: bit0 = commit request (self-clearing), bit1 = auto-commit enable (sticky).
  - 6 and 7 are read-only; writes to them are ignored.
  - 8..15: writes are ignored.
- Register map, reads when chipselect && read:
  - 0..4 return the shadow value.
  - 5 returns {6'b0, auto, 1'b0}.
  - 6 STATUS returns {6'b0, in_vblank, pending}.
  - 7 returns frame_count.
  - 8..15 return 0.
- Vertical-blank timing:
  - vblank_start = (hcount == HTOTAL-1) && (vcount == VACTIVE-1).
  - in_vblank = (vcount >= VACTIVE).
- FSM, two states:
  - IDLE: a CTRL write with bit0=1 moves to ARMED. If auto=1, any shadow write (addresses 0..4) also moves to ARMED.
  - ARMED: on a vblank_start cycle, copy all five shadow registers to the active outputs, pulse irq, and return to IDLE. Further requests while ARMED are absorbed; they cause no extra commit.
- frame_count increments on every vblank_start, whether or not a commit occurs, and wraps 255 to 0.
- Simultaneous events:
  - A shadow write in the same cycle as a commit: the commit copies the pre-write shadow value. The shadow takes the new value. If auto=1, the FSM ends in ARMED, so the new value commits at the next frame.
  - A commit request in the same cycle as vblank_start while IDLE: no commit this frame; the FSM goes to ARMED.
- Reset values:
  - Shadow and active r=8'hFF, g=8'h00, b=8'hFF, pos_x=0, pos_y=0.
  - auto=0, FSM=IDLE, frame_count=0, irq=0, readdata=0.
  - Reset asserted mid-frame or while ARMED discards the pending commit.

## Timing
- Writes land in the shadow bank on the clk edge where the write is sampled.
- Read latency is 1 cycle: readdata is valid the cycle after chipselect && read. When no read is active, readdata holds 0.
- Commit: active outputs and frame_count change on the edge that samples vblank_start. irq is high for exactly that following cycle.
- Worst-case commit latency from request is one frame (VTOTAL*HTOTAL = 840000 cycles).
- Best case: a request made in the cycle before vblank_start commits 1 cycle later.
- The STATUS pending bit reads 1 from the cycle after the request edge through the commit edge.

## Structure
- Shared package vga_pkg holds:
  - HTOTAL, VACTIVE, VTOTAL (also used by vga_counters).
  - The register address enum: REG_R..REG_POS_Y, REG_CTRL, REG_STATUS, REG_FRAME.
  - The FSM state typedef: IDLE, ARMED.
  - The reset colour constants.
- One sub-module, vga_shadow_bank: five 8-bit shadow registers with address decode and a commit copy port. The FSM, frame counter and read mux stay in vga_frame_ctrl.

## Test plan
- Reset, then read addresses 0..7: expect FF,00,FF,00,00,00,00,00, and outputs r=FF g=00 b=FF, irq=0.
- Write r=12, pos_x=34, then CTRL=01 mid-frame (vcount=100):
  - Active outputs are unchanged until vblank_start.
  - The edge after vblank_start gives r=12, pos_x=34, a single-cycle irq, and frame_count=1.
  - STATUS reads 01 before the commit and 00 after it.
- Auto mode: CTRL=02, then write b=55. The next vblank_start commits b=55. With no further writes, the following frame has no irq but frame_count still increments.
- Collision: auto=1, write g=77 in the exact vblank_start cycle while ARMED:
  - This frame commits the old g.
  - The FSM stays ARMED.
  - The next frame commits g=77.
- Request in the same cycle as vblank_start from IDLE: no irq this frame; the commit happens one frame later.
- Run 256 frames: frame_count wraps 255 to 0.
- Assert reset while ARMED: no irq at the next vblank_start, and outputs return to their reset values.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, register map and types for the frame controller
// and the counters that feed it.
package vga_pkg;

    localparam int HTOTAL  = 1600;
    localparam int VACTIVE = 480;
    localparam int VTOTAL  = 525;

    typedef enum logic [3:0] {
        REG_R      = 4'd0,
        REG_G      = 4'd1,
        REG_B      = 4'd2,
        REG_POS_X  = 4'd3,
        REG_POS_Y  = 4'd4,
        REG_CTRL   = 4'd5,
        REG_STATUS = 4'd6,
        REG_FRAME  = 4'd7
    } reg_addr_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] pos_x;
        logic [7:0] pos_y;
    } colour_regs_t;

    localparam logic [7:0] RESET_R     = 8'hFF;
    localparam logic [7:0] RESET_G     = 8'h00;
    localparam logic [7:0] RESET_B     = 8'hFF;
    localparam logic [7:0] RESET_POS_X = 8'h00;
    localparam logic [7:0] RESET_POS_Y = 8'h00;

    localparam colour_regs_t RESET_REGS = '{
        r:     RESET_R,
        g:     RESET_G,
        b:     RESET_B,
        pos_x: RESET_POS_X,
        pos_y: RESET_POS_Y
    };

endpackage

// File: rtl/vga_shadow_bank.sv
// Shadow colour/position registers written by software, plus the active copy
// that is loaded from the shadow on a commit.
module vga_shadow_bank
    import vga_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [3:0]   address,
    input  logic [7:0]   writedata,
    input  logic         commit,
    output colour_regs_t shadow,
    output colour_regs_t active
);

    // The commit copies the pre-edge shadow, so a write on the same edge
    // only reaches the active bank on a later commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= RESET_REGS;
            active <= RESET_REGS;
        end else begin
            if (commit) begin
                active <= shadow;
            end
            if (wr_en) begin
                case (reg_addr_e'(address))
                    REG_R:     shadow.r     <= writedata;
                    REG_G:     shadow.g     <= writedata;
                    REG_B:     shadow.b     <= writedata;
                    REG_POS_X: shadow.pos_x <= writedata;
                    REG_POS_Y: shadow.pos_y <= writedata;
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: rtl/vga_frame_ctrl.sv
// Frame-synchronous register controller: commits the shadow bank to the pixel
// generator at the start of vertical blanking, counts frames, raises irq.
module vga_frame_ctrl
    import vga_pkg::*;
#(
    parameter int HTOTAL  = vga_pkg::HTOTAL,
    parameter int VACTIVE = vga_pkg::VACTIVE,
    parameter int VTOTAL  = vga_pkg::VTOTAL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [3:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic [7:0]  pos_x,
    output logic [7:0]  pos_y,
    output logic [7:0]  frame_count,
    output logic        irq
);

    // Avalon handshake: a write or read is accepted on any edge where
    // chipselect is high with its strobe; there is no wait-state, and
    // readdata answers exactly one cycle later (0 otherwise).
    logic         wr_en;
    logic         rd_en;
    logic         vblank_start;
    logic         in_vblank;
    logic         request;
    logic         commit;
    logic         auto_en;
    state_e       state;
    colour_regs_t shadow;
    colour_regs_t active;

    // VTOTAL only bounds vcount upstream; nothing here depends on it.
    localparam int UNUSED_VTOTAL = VTOTAL;

    assign wr_en        = chipselect && write;
    assign rd_en        = chipselect && read;
    assign vblank_start = (hcount == 11'(HTOTAL - 1)) && (vcount == 10'(VACTIVE - 1));
    assign in_vblank    = (vcount >= 10'(VACTIVE));

    // Auto mode turns any shadow write into a commit request.
    assign request = wr_en && (((reg_addr_e'(address) == REG_CTRL) && writedata[0]) ||
                               (auto_en && (address <= 4'(REG_POS_Y))));
    assign commit  = (state == ARMED) && vblank_start;

    vga_shadow_bank u_shadow_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .address   (address),
        .writedata (writedata),
        .commit    (commit),
        .shadow    (shadow),
        .active    (active)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            auto_en     <= 1'b0;
            frame_count <= 8'd0;
            irq         <= 1'b0;
        end else begin
            irq <= commit;
            if (vblank_start) begin
                frame_count <= frame_count + 8'd1;
            end
            if (wr_en && (reg_addr_e'(address) == REG_CTRL)) begin
                auto_en <= writedata[1];
            end
            case (state)
                IDLE: begin
                    if (request) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    // A request landing on the commit edge keeps us armed for next frame.
                    if (vblank_start) begin
                        state <= request ? ARMED : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 8'd0;
        end else if (rd_en) begin
            case (reg_addr_e'(address))
                REG_R:      readdata <= shadow.r;
                REG_G:      readdata <= shadow.g;
                REG_B:      readdata <= shadow.b;
                REG_POS_X:  readdata <= shadow.pos_x;
                REG_POS_Y:  readdata <= shadow.pos_y;
                REG_CTRL:   readdata <= {6'b0, auto_en, 1'b0};
                REG_STATUS: readdata <= {6'b0, in_vblank, state == ARMED};
                REG_FRAME:  readdata <= frame_count;
                default:    readdata <= 8'd0;
            endcase
        end else begin
            readdata <= 8'd0;
        end
    end

    assign r     = active.r;
    assign g     = active.g;
    assign b     = active.b;
    assign pos_x = active.pos_x;
    assign pos_y = active.pos_y;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Directed bench for vga_frame_ctrl: a register/commit model checked every
// cycle, plus hand-computed literal checks on key points.
module tb_vga_frame_ctrl;
    import vga_pkg::*;

    logic        clk;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [3:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [7:0]  r, g, b, pos_x, pos_y, frame_count;
    logic        irq;

    int checks = 0;
    int errors = 0;

    vga_frame_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .chipselect  (chipselect),
        .write       (write),
        .read        (read),
        .address     (address),
        .writedata   (writedata),
        .readdata    (readdata),
        .hcount      (hcount),
        .vcount      (vcount),
        .r           (r),
        .g           (g),
        .b           (b),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .frame_count (frame_count),
        .irq         (irq)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Software-visible state: shadow/active banks, auto flag, whether a
    // commit is owed at the next vblank start, and frames seen.
    logic [7:0] m_sh[5];
    logic [7:0] m_act[5];
    logic       m_auto;
    logic       m_pending;
    logic [7:0] m_fc;
    logic       m_irq;
    logic [7:0] m_rd;
    logic       s_vbs, s_wr, s_rd, s_req;

    always @(posedge clk) begin
        s_vbs = (hcount == 11'(HTOTAL - 1)) && (vcount == 10'(VACTIVE - 1));
        s_wr  = chipselect && write;
        s_rd  = chipselect && read;
        if (reset) begin
            m_sh[0] = 8'hFF; m_sh[1] = 8'h00; m_sh[2] = 8'hFF; m_sh[3] = 8'h00; m_sh[4] = 8'h00;
            for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
            m_auto = 0; m_pending = 0; m_fc = 0; m_irq = 0; m_rd = 0;
        end else begin
            s_req = s_wr && ((address == 4'd5 && writedata[0]) || (m_auto && address <= 4'd4));
            m_rd = 8'h00;
            if (s_rd) begin
                if (address <= 4'd4)       m_rd = m_sh[address];
                else if (address == 4'd5)  m_rd = {6'b0, m_auto, 1'b0};
                else if (address == 4'd6)  m_rd = {6'b0, vcount >= 10'd480, m_pending};
                else if (address == 4'd7)  m_rd = m_fc;
            end
            m_irq = 0;
            if (s_vbs) begin
                m_fc = m_fc + 8'd1;
                if (m_pending) begin
                    for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
                    m_irq = 1;
                    m_pending = 0;
                end
            end
            if (s_wr && address <= 4'd4) m_sh[address] = writedata;
            if (s_wr && address == 4'd5) m_auto = writedata[1];
            if (s_req) m_pending = 1;
        end
        #1;
        chk("readdata", readdata, m_rd);
        chk("r", r, m_act[0]);
        chk("g", g, m_act[1]);
        chk("b", b, m_act[2]);
        chk("pos_x", pos_x, m_act[3]);
        chk("pos_y", pos_y, m_act[4]);
        chk("frame_count", frame_count, m_fc);
        chk("irq", {7'b0, irq}, {7'b0, m_irq});
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    // One cycle with optional vblank_start and optional register write.
    task automatic cycle(input logic vb, input logic do_wr, input logic [3:0] a, input logic [7:0] d);
        if (vb) begin
            hcount = 11'(HTOTAL - 1);
            vcount = 10'(VACTIVE - 1);
        end
        chipselect = do_wr;
        write      = do_wr;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 0; write = 0;
        hcount = 11'd0; vcount = 10'd100;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
        cycle(1'b0, 1'b1, a, d);
    endtask

    task automatic vblank();
        cycle(1'b1, 1'b0, 4'd0, 8'd0);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        chipselect = 1; read = 1; address = a;
        tick();
        chipselect = 0; read = 0;
        chk(name, readdata, exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1; chipselect = 0; write = 0; read = 0;
        address = 0; writedata = 0; hcount = 0; vcount = 10'd100;
        tick(); tick();
        reset = 0;
        tick();

        // Reset values
        rd_chk("rst_r", 4'd0, 8'hFF);
        rd_chk("rst_g", 4'd1, 8'h00);
        rd_chk("rst_b", 4'd2, 8'hFF);
        rd_chk("rst_px", 4'd3, 8'h00);
        rd_chk("rst_py", 4'd4, 8'h00);
        rd_chk("rst_ctrl", 4'd5, 8'h00);
        rd_chk("rst_status", 4'd6, 8'h00);
        rd_chk("rst_frame", 4'd7, 8'h00);
        chk("rst_out_r", r, 8'hFF);
        chk("rst_out_g", g, 8'h00);
        chk("rst_out_b", b, 8'hFF);
        chk("rst_irq", {7'b0, irq}, 8'h00);

        // Manual commit
        wr_reg(4'd0, 8'h12);
        wr_reg(4'd3, 8'h34);
        wr_reg(4'd5, 8'h01);
        rd_chk("status_pending", 4'd6, 8'h01);
        chk("r_before_commit", r, 8'hFF);
        vblank();
        chk("r_commit", r, 8'h12);
        chk("px_commit", pos_x, 8'h34);
        chk("irq_commit", {7'b0, irq}, 8'h01);
        chk("fc_1", frame_count, 8'd1);
        tick();
        chk("irq_one_cycle", {7'b0, irq}, 8'h00);
        rd_chk("status_clear", 4'd6, 8'h00);

        // Auto mode
        wr_reg(4'd5, 8'h02);
        rd_chk("ctrl_auto", 4'd5, 8'h02);
        wr_reg(4'd2, 8'h55);
        vblank();
        chk("b_auto", b, 8'h55);
        chk("irq_auto", {7'b0, irq}, 8'h01);
        tick();
        vblank();
        chk("irq_none", {7'b0, irq}, 8'h00);
        chk("fc_3", frame_count, 8'd3);

        // Collision: write g while ARMED on the vblank_start cycle
        wr_reg(4'd4, 8'h09);
        cycle(1'b1, 1'b1, 4'd1, 8'h77);
        chk("g_old", g, 8'h00);
        chk("py_coll", pos_y, 8'h09);
        chk("irq_coll", {7'b0, irq}, 8'h01);
        rd_chk("status_rearmed", 4'd6, 8'h01);
        vblank();
        chk("g_new", g, 8'h77);
        chk("fc_5", frame_count, 8'd5);

        // Request on the vblank_start cycle from IDLE
        wr_reg(4'd5, 8'h00);
        wr_reg(4'd0, 8'hAA);
        cycle(1'b1, 1'b1, 4'd5, 8'h01);
        chk("irq_late_req", {7'b0, irq}, 8'h00);
        chk("r_late_req", r, 8'h12);
        rd_chk("status_late", 4'd6, 8'h01);
        vblank();
        chk("r_next_frame", r, 8'hAA);
        chk("fc_7", frame_count, 8'd7);

        // in_vblank boundary
        hcount = 11'd1598; vcount = 10'd479;
        rd_chk("status_line479", 4'd6, 8'h00);
        hcount = 11'd0; vcount = 10'd480;
        rd_chk("status_line480", 4'd6, 8'h02);
        vcount = 10'd100;
        rd_chk("rd_hi_addr", 4'd12, 8'h00);
        wr_reg(4'd9, 8'h5A);
        wr_reg(4'd6, 8'h5A);
        rd_chk("r_unchanged", 4'd0, 8'hAA);

        // Frame counter wrap
        repeat (248) vblank();
        chk("fc_255", frame_count, 8'd255);
        vblank();
        chk("fc_wrap", frame_count, 8'd0);
        repeat (7) vblank();
        chk("fc_7_again", frame_count, 8'd7);

        // Reset while ARMED
        wr_reg(4'd0, 8'h01);
        wr_reg(4'd5, 8'h01);
        reset = 1;
        tick();
        reset = 0;
        chk("r_after_rst", r, 8'hFF);
        rd_chk("status_after_rst", 4'd6, 8'h00);
        vblank();
        chk("irq_after_rst", {7'b0, irq}, 8'h00);
        chk("fc_after_rst", frame_count, 8'd1);
        chk("r_still_rst", r, 8'hFF);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
